// File: rtl/rob_flush_pkg.sv
// Shared types for the reorder buffer: instruction-type codes and the entry record.
package rob_flush_pkg;

    localparam logic [3:0] ITYPE_ALU    = 4'd0;
    localparam logic [3:0] ITYPE_LOAD   = 4'd1;
    localparam logic [3:0] ITYPE_STORE  = 4'd2;
    localparam logic [3:0] ITYPE_BRANCH = 4'd3;

    // One reorder-buffer slot. For a STORE, dest holds the base address and
    // accumulates the CDB offset once the store resolves.
    typedef struct packed {
        logic        valid;
        logic        ready;
        logic [3:0]  itype;
        logic [31:0] value;
        logic [31:0] dest;
    } rob_entry_t;

    function automatic logic is_store(input logic [3:0] itype);
        return itype == ITYPE_STORE;
    endfunction

endpackage

// File: rtl/rob_flush_load_check.sv
// Older-store scan for one load channel: blocks the load if any valid store
// between head (inclusive) and the load's own entry (exclusive) is unresolved
// or resolved to the same address.
module rob_flush_load_check
    import rob_flush_pkg::*;
#(
    parameter int SIZE = 8,
    localparam int PTR_W = $clog2(SIZE)
) (
    input  logic [PTR_W-1:0] head_in,
    input  logic [SIZE-1:0]  ent_valid_in,
    input  logic [SIZE-1:0]  ent_ready_in,
    input  logic [3:0]       ent_itype_in [SIZE],
    input  logic [31:0]      ent_dest_in  [SIZE],
    input  logic [PTR_W-1:0] lb_rob_ix_in,
    input  logic [31:0]      lb_dest_in,
    output logic             can_load_out
);

    logic [PTR_W-1:0] lim;
    logic [PTR_W-1:0] age [SIZE];
    logic [SIZE-1:0]  blocks;

    // Age of each slot relative to head; only slots younger than head and older than the load count.
    always_comb begin
        lim = lb_rob_ix_in - head_in;
        for (int i = 0; i < SIZE; i++) begin
            age[i]    = PTR_W'(i) - head_in;
            blocks[i] = ent_valid_in[i] && is_store(ent_itype_in[i]) && (age[i] < lim) &&
                        (!ent_ready_in[i] || (ent_dest_in[i] == lb_dest_in));
        end
        can_load_out = ~|blocks;
    end

endmodule

// File: rtl/rob_flush.sv
// Reorder buffer with mispredict flush, same-cycle CDB forwarding to decode,
// and an occupancy counter for exact full/empty.
//
// Handshakes: an issue is accepted on any cycle where valid_in && ready_out &&
// !flush_in; a head store is retired on any cycle where store_valid_out &&
// store_read_in (store_read_in alone does nothing). Non-store commits need no
// acknowledge: commit_out high means head advances on that edge.
module rob_flush
    import rob_flush_pkg::*;
#(
    parameter int SIZE   = 8,
    parameter int NUM_LD = 3,
    localparam int PTR_W = $clog2(SIZE)
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic [PTR_W-1:0]  decode_rob1_ix_in,
    input  logic [PTR_W-1:0]  decode_rob2_ix_in,
    input  logic              valid_in,
    input  logic [3:0]        iType_in,
    input  logic [31:0]       value_in,
    input  logic [31:0]       dest_in,
    input  logic              cdb_valid_in,
    input  logic [PTR_W-1:0]  cdb_rob_ix_in,
    input  logic [31:0]       cdb_value_in,
    input  logic [31:0]       cdb_dest_in,
    input  logic [PTR_W-1:0]  lb_rob_ix_in [NUM_LD],
    input  logic [31:0]       lb_dest_in   [NUM_LD],
    input  logic              store_read_in,
    input  logic              flush_in,
    input  logic [PTR_W-1:0]  flush_rob_ix_in,
    output logic              can_load_out [NUM_LD],
    output logic [31:0]       decode_value1_out,
    output logic [31:0]       decode_value2_out,
    output logic              decode_ready1_out,
    output logic              decode_ready2_out,
    output logic [PTR_W-1:0]  inst_rob_ix_out,
    output logic [PTR_W-1:0]  ix_out,
    output logic [3:0]        iType_out,
    output logic [31:0]       value_out,
    output logic [31:0]       dest_out,
    output logic              ready_out,
    output logic              commit_out,
    output logic              store_valid_out,
    output logic [PTR_W:0]    count_out
);

    rob_entry_t       entries_q [SIZE];
    rob_entry_t       entries_d [SIZE];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W:0]   count_q, count_d;

    rob_entry_t       head_e;
    logic             do_issue;
    logic             retire;
    logic [PTR_W-1:0] flush_age;
    logic [PTR_W-1:0] age [SIZE];
    logic [SIZE-1:0]  squash;
    logic [PTR_W:0]   squash_cnt;

    logic [SIZE-1:0]  ent_valid;
    logic [SIZE-1:0]  ent_ready;
    logic [3:0]       ent_itype [SIZE];
    logic [31:0]      ent_dest  [SIZE];

    assign head_e          = entries_q[head_q];
    assign ix_out          = head_q;
    assign iType_out       = head_e.itype;
    assign value_out       = head_e.value;
    assign dest_out        = head_e.dest;
    assign inst_rob_ix_out = tail_q;
    assign count_out       = count_q;
    assign ready_out       = count_q < (PTR_W+1)'(SIZE);
    assign commit_out      = head_e.valid & head_e.ready & ~is_store(head_e.itype);
    assign store_valid_out = head_e.valid & head_e.ready &  is_store(head_e.itype);
    assign retire          = commit_out | (store_valid_out & store_read_in);
    assign do_issue        = valid_in & ready_out & ~flush_in;

    // Operand lookup, with a same-cycle CDB result taking priority over the stored copy.
    always_comb begin
        if (cdb_valid_in && (cdb_rob_ix_in == decode_rob1_ix_in)) begin
            decode_value1_out = cdb_value_in;
            decode_ready1_out = 1'b1;
        end else begin
            decode_value1_out = entries_q[decode_rob1_ix_in].value;
            decode_ready1_out = entries_q[decode_rob1_ix_in].valid & entries_q[decode_rob1_ix_in].ready;
        end
        if (cdb_valid_in && (cdb_rob_ix_in == decode_rob2_ix_in)) begin
            decode_value2_out = cdb_value_in;
            decode_ready2_out = 1'b1;
        end else begin
            decode_value2_out = entries_q[decode_rob2_ix_in].value;
            decode_ready2_out = entries_q[decode_rob2_ix_in].valid & entries_q[decode_rob2_ix_in].ready;
        end
    end

    // Mark live entries younger than the mispredicted branch and count them.
    always_comb begin
        flush_age  = flush_rob_ix_in - head_q;
        squash_cnt = '0;
        for (int i = 0; i < SIZE; i++) begin
            age[i]     = PTR_W'(i) - head_q;
            squash[i]  = flush_in && entries_q[i].valid && (age[i] > flush_age);
            squash_cnt = squash_cnt + (PTR_W+1)'(squash[i]);
        end
    end

    // Next state: CDB write, then retire, then squash, then allocate.
    always_comb begin
        entries_d = entries_q;
        head_d    = head_q;
        tail_d    = tail_q;

        if (cdb_valid_in && entries_q[cdb_rob_ix_in].valid && !squash[cdb_rob_ix_in]) begin
            entries_d[cdb_rob_ix_in].value = cdb_value_in;
            entries_d[cdb_rob_ix_in].ready = 1'b1;
            if (is_store(entries_q[cdb_rob_ix_in].itype)) begin
                entries_d[cdb_rob_ix_in].dest = entries_q[cdb_rob_ix_in].dest + cdb_dest_in;
            end
        end

        if (retire) begin
            entries_d[head_q].valid = 1'b0;
            entries_d[head_q].ready = 1'b0;
            head_d = head_q + 1'b1;
        end

        for (int i = 0; i < SIZE; i++) begin
            if (squash[i]) begin
                entries_d[i].valid = 1'b0;
                entries_d[i].ready = 1'b0;
            end
        end

        if (do_issue) begin
            entries_d[tail_q] = '{valid: 1'b1, ready: 1'b0, itype: iType_in,
                                  value: value_in, dest: dest_in};
            tail_d = tail_q + 1'b1;
        end
        if (flush_in) begin
            tail_d = flush_rob_ix_in + 1'b1;
        end

        count_d = count_q + (PTR_W+1)'(do_issue) - (PTR_W+1)'(retire) - squash_cnt;
    end

    // State register; reset empties the buffer in a single cycle.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < SIZE; i++) begin
                entries_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            for (int i = 0; i < SIZE; i++) begin
                entries_q[i] <= entries_d[i];
            end
        end
    end

    for (genvar g = 0; g < SIZE; g++) begin : g_ent
        assign ent_valid[g] = entries_q[g].valid;
        assign ent_ready[g] = entries_q[g].ready;
        assign ent_itype[g] = entries_q[g].itype;
        assign ent_dest[g]  = entries_q[g].dest;
    end

    for (genvar g = 0; g < NUM_LD; g++) begin : g_ld
        rob_flush_load_check #(.SIZE(SIZE)) u_check (
            .head_in      (head_q),
            .ent_valid_in (ent_valid),
            .ent_ready_in (ent_ready),
            .ent_itype_in (ent_itype),
            .ent_dest_in  (ent_dest),
            .lb_rob_ix_in (lb_rob_ix_in[g]),
            .lb_dest_in   (lb_dest_in[g]),
            .can_load_out (can_load_out[g])
        );
    end

endmodule

// File: tb/tb_rob_flush.sv
// Bench for rob_flush: directed sequences, a load-check vector table, and a
// randomized run compared against a queue-based model of the buffer.
module tb_rob_flush;
    import rob_flush_pkg::*;

    localparam int SIZE   = 8;
    localparam int NUM_LD = 3;
    localparam int PTR_W  = $clog2(SIZE);

    // ---------------- clock / reset ----------------
    logic clk_in = 1'b0;
    logic rst_in;
    always #5 clk_in = ~clk_in;

    logic [PTR_W-1:0] decode_rob1_ix_in, decode_rob2_ix_in;
    logic             valid_in;
    logic [3:0]       iType_in;
    logic [31:0]      value_in, dest_in;
    logic             cdb_valid_in;
    logic [PTR_W-1:0] cdb_rob_ix_in;
    logic [31:0]      cdb_value_in, cdb_dest_in;
    logic [PTR_W-1:0] lb_rob_ix_in [NUM_LD];
    logic [31:0]      lb_dest_in   [NUM_LD];
    logic             store_read_in;
    logic             flush_in;
    logic [PTR_W-1:0] flush_rob_ix_in;
    logic             can_load_out [NUM_LD];
    logic [31:0]      decode_value1_out, decode_value2_out;
    logic             decode_ready1_out, decode_ready2_out;
    logic [PTR_W-1:0] inst_rob_ix_out, ix_out;
    logic [3:0]       iType_out;
    logic [31:0]      value_out, dest_out;
    logic             ready_out, commit_out, store_valid_out;
    logic [PTR_W:0]   count_out;

    rob_flush #(.SIZE(SIZE), .NUM_LD(NUM_LD)) dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .decode_rob1_ix_in(decode_rob1_ix_in), .decode_rob2_ix_in(decode_rob2_ix_in),
        .valid_in(valid_in), .iType_in(iType_in), .value_in(value_in), .dest_in(dest_in),
        .cdb_valid_in(cdb_valid_in), .cdb_rob_ix_in(cdb_rob_ix_in),
        .cdb_value_in(cdb_value_in), .cdb_dest_in(cdb_dest_in),
        .lb_rob_ix_in(lb_rob_ix_in), .lb_dest_in(lb_dest_in),
        .store_read_in(store_read_in), .flush_in(flush_in), .flush_rob_ix_in(flush_rob_ix_in),
        .can_load_out(can_load_out),
        .decode_value1_out(decode_value1_out), .decode_value2_out(decode_value2_out),
        .decode_ready1_out(decode_ready1_out), .decode_ready2_out(decode_ready2_out),
        .inst_rob_ix_out(inst_rob_ix_out), .ix_out(ix_out), .iType_out(iType_out),
        .value_out(value_out), .dest_out(dest_out), .ready_out(ready_out),
        .commit_out(commit_out), .store_valid_out(store_valid_out), .count_out(count_out)
    );

    // ---------------- scoreboard ----------------
    int checks   = 0;
    int failures = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
        end
    endfunction

    // ---------------- reference model ----------------
    // Live entries in age order; element k sits at slot (m_head + k) mod SIZE.
    typedef struct {
        logic [3:0]  itype;
        logic [31:0] value;
        logic [31:0] dest;
        bit          ready;
    } m_ent_t;

    m_ent_t m_q[$];
    int     m_head = 0;

    function automatic int rel(int ix);
        return (ix - m_head + SIZE) % SIZE;
    endfunction

    function automatic bit exp_can(int ix, logic [31:0] addr);
        int lim = rel(ix);
        for (int k = 0; k < lim && k < m_q.size(); k++) begin
            if (m_q[k].itype == ITYPE_STORE && (!m_q[k].ready || m_q[k].dest == addr)) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic void dec_chk(string nm, int idx, logic [31:0] av, logic ar);
        int off = rel(idx);
        if (cdb_valid_in && int'(cdb_rob_ix_in) == idx) begin
            chk({nm, "_fwd_val"}, av, cdb_value_in);
            chk({nm, "_fwd_rdy"}, 32'(ar), 1);
        end else if (off < m_q.size()) begin
            chk({nm, "_val"}, av, m_q[off].value);
            chk({nm, "_rdy"}, 32'(ar), 32'(m_q[off].ready));
        end else begin
            chk({nm, "_rdy_invalid"}, 32'(ar), 0);
        end
    endfunction

    function automatic void check_model();
        int cnt = m_q.size();
        chk("count", 32'(count_out), cnt);
        chk("ready_out", 32'(ready_out), 32'(cnt < SIZE));
        chk("inst_ix", 32'(inst_rob_ix_out), (m_head + cnt) % SIZE);
        chk("ix_out", 32'(ix_out), m_head);
        chk("commit", 32'(commit_out),
            32'(cnt > 0 && m_q[0].ready && m_q[0].itype != ITYPE_STORE));
        chk("store_valid", 32'(store_valid_out),
            32'(cnt > 0 && m_q[0].ready && m_q[0].itype == ITYPE_STORE));
        if (cnt > 0) begin
            chk("head_itype", 32'(iType_out), 32'(m_q[0].itype));
            chk("head_value", value_out, m_q[0].value);
            chk("head_dest", dest_out, m_q[0].dest);
        end
        dec_chk("dec1", int'(decode_rob1_ix_in), decode_value1_out, decode_ready1_out);
        dec_chk("dec2", int'(decode_rob2_ix_in), decode_value2_out, decode_ready2_out);
        for (int c = 0; c < NUM_LD; c++) begin
            chk($sformatf("can_load%0d", c), 32'(can_load_out[c]),
                32'(exp_can(int'(lb_rob_ix_in[c]), lb_dest_in[c])));
        end
    endfunction

    function automatic void model_step();
        int     cnt = m_q.size();
        int     foff;
        int     off;
        bit     retire;
        bit     issue;
        m_ent_t e;
        if (rst_in) begin
            m_q.delete();
            m_head = 0;
            return;
        end
        foff   = rel(int'(flush_rob_ix_in));
        issue  = valid_in && cnt < SIZE && !flush_in;
        retire = cnt > 0 && m_q[0].ready && (m_q[0].itype != ITYPE_STORE || store_read_in);
        if (cdb_valid_in) begin
            off = rel(int'(cdb_rob_ix_in));
            if (off < cnt && !(flush_in && off > foff)) begin
                e = m_q[off];
                e.value = cdb_value_in;
                e.ready = 1'b1;
                if (e.itype == ITYPE_STORE) e.dest = e.dest + cdb_dest_in;
                m_q[off] = e;
            end
        end
        if (retire) begin
            void'(m_q.pop_front());
            m_head = (m_head + 1) % SIZE;
        end
        if (flush_in) begin
            while (m_q.size() > foff + 1 - int'(retire)) void'(m_q.pop_back());
        end
        if (issue) begin
            e.itype = iType_in; e.value = value_in; e.dest = dest_in; e.ready = 1'b0;
            m_q.push_back(e);
        end
    endfunction

    // ---------------- driver tasks ----------------
    task automatic idle();
        rst_in = 1'b0; valid_in = 1'b0; iType_in = ITYPE_ALU; value_in = '0; dest_in = '0;
        cdb_valid_in = 1'b0; cdb_rob_ix_in = '0; cdb_value_in = '0; cdb_dest_in = '0;
        store_read_in = 1'b0; flush_in = 1'b0; flush_rob_ix_in = '0;
        decode_rob1_ix_in = '0; decode_rob2_ix_in = '0;
        for (int c = 0; c < NUM_LD; c++) begin
            lb_rob_ix_in[c] = '0;
            lb_dest_in[c]   = '0;
        end
    endtask

    task automatic settle();
        #4;
    endtask

    task automatic advance();
        if (!rst_in) check_model();
        model_step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic cycle();
        settle();
        advance();
    endtask

    task automatic do_reset();
        idle(); rst_in = 1'b1; cycle(); idle();
    endtask

    task automatic issue(input logic [3:0] t, input logic [31:0] v, input logic [31:0] d);
        valid_in = 1'b1; iType_in = t; value_in = v; dest_in = d;
        cycle(); idle();
    endtask

    task automatic cdb(input int ix, input logic [31:0] v, input logic [31:0] d);
        cdb_valid_in = 1'b1; cdb_rob_ix_in = PTR_W'(ix); cdb_value_in = v; cdb_dest_in = d;
        cycle(); idle();
    endtask

    // ---------------- load-check vector table ----------------
    typedef struct {
        int          lb_ix;
        logic [31:0] lb_dest;
        bit          exp_can;
    } ld_vec_t;

    ld_vec_t ld_tab[8];

    initial begin
        // ROB for the table: 0 ALU pending, 1 STORE resolved to 0x200, 2 ALU,
        // 3 LOAD, 4 STORE pending, 5 LOAD.
        ld_tab[0] = '{3, 32'h200, 1'b0};
        ld_tab[1] = '{3, 32'h204, 1'b1};
        ld_tab[2] = '{0, 32'h200, 1'b1};
        ld_tab[3] = '{1, 32'h200, 1'b1};
        ld_tab[4] = '{2, 32'h200, 1'b0};
        ld_tab[5] = '{5, 32'h204, 1'b0};
        ld_tab[6] = '{4, 32'h300, 1'b1};
        ld_tab[7] = '{4, 32'h1F0, 1'b1};

        // ---- reset state ----
        do_reset();
        settle();
        chk("rst_ready", 32'(ready_out), 1);
        chk("rst_commit", 32'(commit_out), 0);
        chk("rst_store_valid", 32'(store_valid_out), 0);
        chk("rst_count", 32'(count_out), 0);
        chk("rst_inst_ix", 32'(inst_rob_ix_out), 0);
        chk("rst_ix_out", 32'(ix_out), 0);
        for (int c = 0; c < NUM_LD; c++) chk("rst_can_load", 32'(can_load_out[c]), 1);
        advance();

        // ---- fill and wrap ----
        for (int i = 0; i < SIZE; i++) issue(ITYPE_ALU, 32'h10 + i, 32'(i));
        settle();
        chk("full_ready", 32'(ready_out), 0);
        chk("full_count", 32'(count_out), SIZE);
        advance();
        issue(ITYPE_ALU, 32'hDEAD, 0);                 // ignored while full
        settle();
        chk("full_ignore_count", 32'(count_out), SIZE);
        advance();
        cdb(0, 32'hAA, 0);
        settle();
        chk("wrap_commit", 32'(commit_out), 1);
        chk("wrap_head_before", 32'(ix_out), 0);
        chk("wrap_value", value_out, 32'hAA);
        advance();
        settle();
        chk("wrap_head_after", 32'(ix_out), 1);
        chk("wrap_count", 32'(count_out), SIZE - 1);
        chk("wrap_inst_ix", 32'(inst_rob_ix_out), 0);
        advance();
        issue(ITYPE_ALU, 32'h99, 0);
        decode_rob1_ix_in = 0;
        settle();
        chk("wrap_slot0_val", decode_value1_out, 32'h99);
        chk("wrap_slot0_rdy", 32'(decode_ready1_out), 0);
        chk("wrap_count_full", 32'(count_out), SIZE);
        advance(); idle();

        // ---- CDB forwarding to decode ----
        cdb_valid_in = 1'b1; cdb_rob_ix_in = 2; cdb_value_in = 32'h55;
        decode_rob1_ix_in = 2; decode_rob2_ix_in = 3;
        settle();
        chk("fwd_val", decode_value1_out, 32'h55);
        chk("fwd_rdy", 32'(decode_ready1_out), 1);
        chk("fwd_other_rdy", 32'(decode_ready2_out), 0);
        advance(); idle();

        // ---- reset mid-stream ----
        do_reset();
        for (int i = 0; i < 5; i++) issue(ITYPE_ALU, 32'(i), 0);
        cdb(0, 32'h1, 0);
        rst_in = 1'b1; cycle(); idle();
        settle();
        chk("midrst_count", 32'(count_out), 0);
        chk("midrst_commit", 32'(commit_out), 0);
        chk("midrst_ready", 32'(ready_out), 1);
        advance();

        // ---- store retire ----
        issue(ITYPE_STORE, 32'h0, 32'h100);
        cdb(0, 32'hABCD, 32'h4);
        for (int k = 0; k < 2; k++) begin
            settle();
            chk("st_valid_hold", 32'(store_valid_out), 1);
            chk("st_dest", dest_out, 32'h104);
            chk("st_commit", 32'(commit_out), 0);
            chk("st_head_hold", 32'(ix_out), 0);
            advance();
        end
        store_read_in = 1'b1; cycle(); idle();
        settle();
        chk("st_head_adv", 32'(ix_out), 1);
        chk("st_valid_done", 32'(store_valid_out), 0);
        chk("st_count", 32'(count_out), 0);
        advance();

        // ---- load disambiguation ----
        do_reset();
        issue(ITYPE_ALU,   32'h0, 32'h1);
        issue(ITYPE_STORE, 32'h0, 32'h1F0);
        issue(ITYPE_ALU,   32'h0, 32'h2);
        issue(ITYPE_LOAD,  32'h0, 32'h3);
        issue(ITYPE_STORE, 32'h0, 32'h300);
        issue(ITYPE_LOAD,  32'h0, 32'h5);
        lb_rob_ix_in[0] = 3; lb_dest_in[0] = 32'h200;
        settle();
        chk("ld_pending_store", 32'(can_load_out[0]), 0);
        advance(); idle();
        cdb(1, 32'h0, 32'h10);
        for (int v = 0; v < 8; v++) begin
            idle();
            lb_rob_ix_in[v % NUM_LD] = PTR_W'(ld_tab[v].lb_ix);
            lb_dest_in[v % NUM_LD]   = ld_tab[v].lb_dest;
            settle();
            for (int c = 0; c < NUM_LD; c++) begin
                chk($sformatf("ld_vec%0d_ch%0d", v, c), 32'(can_load_out[c]),
                    (c == v % NUM_LD) ? 32'(ld_tab[v].exp_can) : 32'd1);
            end
            advance();
        end
        idle();

        // ---- flush ----
        do_reset();
        for (int i = 0; i < 6; i++) issue(ITYPE_ALU, 32'(i), 0);
        flush_in = 1'b1; flush_rob_ix_in = 2;
        valid_in = 1'b1; iType_in = ITYPE_ALU; value_in = 32'hBAD;
        cycle(); idle();
        settle();
        chk("flush_count", 32'(count_out), 3);
        chk("flush_tail", 32'(inst_rob_ix_out), 3);
        advance();
        cdb(4, 32'h77, 0);
        decode_rob1_ix_in = 4;
        settle();
        chk("flush_cdb_ignored", 32'(decode_ready1_out), 0);
        chk("flush_count_hold", 32'(count_out), 3);
        chk("flush_no_commit", 32'(commit_out), 0);
        advance(); idle();
        flush_in = 1'b1; flush_rob_ix_in = 0;
        cycle(); idle();
        settle();
        chk("flush_head_count", 32'(count_out), 1);
        chk("flush_head_tail", 32'(inst_rob_ix_out), 1);
        advance();

        // ---- randomized run against the model ----
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            idle();
            valid_in = ($urandom_range(0, 9) < 6);
            iType_in = ($urandom_range(0, 2) == 0) ? ITYPE_STORE : 4'($urandom_range(0, 15));
            value_in = $urandom;
            dest_in  = 32'h100 * $urandom_range(1, 3);
            cdb_valid_in  = $urandom_range(0, 1) == 1;
            cdb_rob_ix_in = PTR_W'($urandom_range(0, SIZE - 1));
            cdb_value_in  = $urandom;
            cdb_dest_in   = ($urandom_range(0, 1) == 1) ? 32'h100 : 32'h0;
            store_read_in = $urandom_range(0, 1) == 1;
            decode_rob1_ix_in = PTR_W'($urandom_range(0, SIZE - 1));
            decode_rob2_ix_in = PTR_W'($urandom_range(0, SIZE - 1));
            for (int c = 0; c < NUM_LD; c++) begin
                lb_rob_ix_in[c] = PTR_W'($urandom_range(0, SIZE - 1));
                lb_dest_in[c]   = 32'h100 * $urandom_range(1, 5);
            end
            if (m_q.size() > 0 && $urandom_range(0, 19) == 0) begin
                flush_in = 1'b1;
                flush_rob_ix_in = PTR_W'((m_head + $urandom_range(0, m_q.size() - 1)) % SIZE);
            end
            if ($urandom_range(0, 299) == 0) rst_in = 1'b1;
            cycle();
        end
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rob_flush.md
Name: rob_flush

Overview:
- Parametrised reorder buffer for the superscalar core: depth `SIZE`, `NUM_LD` load-disambiguation channels.
- Adds branch-mispredict flush, same-cycle CDB forwarding to decode, and an occupancy counter giving exact full/empty at any power-of-two depth.
- Sits between decode/issue, the CDB, the load buffer, and the register file / memory commit path.

Parameters:
- `SIZE`, 8, number of entries; power of two, ≥2.
- `NUM_LD`, 3, number of load-buffer check channels.
- `PTR_W`, `$clog2(SIZE)`, derived entry-index width; not overridable.

Ports:
- `clk_in`  in  1  clock
- `rst_in`  in  1  synchronous active-high reset
- `decode_rob1_ix_in`, `decode_rob2_ix_in`  in  PTR_W  operand lookup indices
- `valid_in`  in  1  issue request
- `iType_in`  in  4  instruction type
- `value_in`  in  32  initial value
- `dest_in`  in  32  destination register, or store base address
- `cdb_valid_in`  in  1  CDB broadcast valid
- `cdb_rob_ix_in`  in  PTR_W  CDB entry index
- `cdb_value_in`  in  32  result
- `cdb_dest_in`  in  32  store address offset
- `lb_rob_ix_in[NUM_LD]`  in  PTR_W each  load entry index
- `lb_dest_in[NUM_LD]`  in  32 each  load address
- `store_read_in`  in  1  memory accepted head store (one-cycle pulse)
- `flush_in`  in  1  mispredict flush
- `flush_rob_ix_in`  in  PTR_W  index of the mispredicted branch; it survives
- `can_load_out[NUM_LD]`  out  1 each  load may proceed
- `decode_value1_out`, `decode_value2_out`  out  32  operand values
- `decode_ready1_out`, `decode_ready2_out`  out  1  operand ready flags
- `inst_rob_ix_out`  out  PTR_W  tail index for the next issue
- `ix_out`  out  PTR_W  head index
- `iType_out`  out  4  head type
- `value_out`  out  32  head value
- `dest_out`  out  32  head destination
- `ready_out`  out  1  space available
- `commit_out`  out  1  head non-store is committing
- `store_valid_out`  out  1  head store presented to memory
- `count_out`  out  PTR_W+1  occupancy

Behaviour:
- State:
  - `head`, `tail`: PTR_W bits, natural wrap.
  - `count`: PTR_W+1 bits.
  - Per entry: `valid`, `ready`, `iType`, `value`, `dest`.
- Reset:
  - `head = tail = count = 0`; all `valid` and `ready` bits cleared.
  - Outputs after reset: `ready_out = 1`, `commit_out = 0`, `store_valid_out = 0`, `count_out = 0`, `inst_rob_ix_out = 0`, `ix_out = 0`, `can_load_out` all 1.
  - Reset asserted mid-operation discards all entries in one cycle.
- Capacity: `ready_out = (count < SIZE)`. When full, issue is ignored.
- Issue: when `valid_in && ready_out && !flush_in`:
  - Write the entry at `tail` with `valid = 1`, `ready = 0`.
  - Increment `tail`.
  - `inst_rob_ix_out` shows the allocated index in the same cycle.
- CDB write: when `cdb_valid_in` and the entry is valid:
  - `value <= cdb_value_in`; `ready <= 1`.
  - If the entry is a STORE: `dest <= dest + cdb_dest_in` (32-bit wrap).
  - CDB to an invalid entry is ignored.
- Commit (non-store): `commit_out = valid[head] & ready[head] & (iType != STORE)`.
  - No acknowledge: `head` advances and the entry is cleared on the same edge.
- Store commit: `store_valid_out = valid[head] & ready[head] & (iType == STORE)`.
  - Head is held until `store_read_in`; `store_read_in` without `store_valid_out` is ignored.
- Head outputs: `ix_out`, `iType_out`, `value_out`, `dest_out` always reflect `head`.
- Decode lookup:
  - If `cdb_valid_in` and `cdb_rob_ix_in` equals the lookup index, output `cdb_value_in` with ready = 1 (forward).
  - Otherwise output the stored value and ready.
  - An invalid entry reports ready = 0.
- Flush: on `flush_in`:
  - Clear `valid` on every entry strictly younger than `flush_rob_ix_in`, up to `tail`.
  - `tail <= flush_rob_ix_in + 1`; count is recomputed.
  - Same-cycle issue is dropped; same-cycle CDB writes to squashed entries are dropped.
  - A same-cycle commit of `head` still occurs.
  - Flush of the head entry itself retains only that entry.
- Count: `count` next = `count + issue − (commit | store retire) − squashed`. Issue and retire in the same cycle leave count unchanged.
- Load check, per channel i, combinational:
  - Scan valid entries from `head` up to, but excluding, `lb_rob_ix_in[i]`.
  - `can_load_out[i] = 0` if any STORE is either not ready, or ready with `dest == lb_dest_in[i]`.
  - Otherwise `can_load_out[i] = 1`.
- Wrap-around: all index arithmetic is modulo `SIZE`. Full (`count == SIZE`) and empty (`count == 0`) are distinguished when `head == tail`.

Decomposition:
- STORE and the other iType constants stay in the shared `types.svh` package; add a `rob_entry_t` struct there.
- One natural sub-module: `rob_load_check`, the per-channel older-store scan, instantiated `NUM_LD` times.

Test Plan:
- Fill and wrap: reset, issue 8 ALU entries → `ready_out = 0` and `count_out = 8`; CDB completes entry 0 → `commit_out = 1`, head 0→1; issue a 9th → written at index 0.
- CDB forwarding: entry 2 pending; in the same cycle `cdb_valid_in` with ix 2, value 0x55, and `decode_rob1_ix_in = 2` → `decode_value1_out = 0x55`, `decode_ready1_out = 1`.
- Store retire: store issued with dest 0x100, CDB `cdb_dest_in = 4` → `store_valid_out = 1`, `dest_out = 0x104`; head held until `store_read_in`, then advances.
- Load disambiguation:
  - Store at entry 1, pending → load at entry 3 gets `can_load_out[0] = 0`.
  - After the store resolves to 0x200: load address 0x200 → 0; load address 0x204 → 1.
- Flush: entries 0–5 live, `flush_in` with ix 2 → tail = 3, `count_out = 3`; a later CDB to entry 4 is ignored; a simultaneous `valid_in` is dropped.
- Reset mid-stream: 5 entries live, pulse `rst_in` → next cycle `count_out = 0`, `commit_out = 0`, `ready_out = 1`.
